uart_tx_arbiter: RTL and testbench

Round-robin arbiter sharing the single UART transmitter between NUM_REQ byte-stream clients (debug console, status reporter, loopback, ...). Grants one requester at a time and holds the grant for a whole packet, delimited by req_last, so packets never interleave on serial_tx. Sits directly in front of the uart block's tx_byte/tx_valid/tx_ready port; a transfer occurs on any cycle with uart_tx_valid && uart_tx_ready.

---
 rtl/uart_tx_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one UART transmitter between
// NUM_REQ byte-stream clients. A grant is held for a whole packet (ended by
// req_last), so packets never interleave. A grant is force-released after
// MAX_PKT bytes, or after IDLE_TIMEOUT cycles with the granted req_valid low.
//
// Optional feature: define UART_ARB_HEADER_EN to send a header byte
// {4'hA, grant index} before each packet.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   req_valid/req_last  per-requester byte valid / final-byte-of-packet flag
//   req_data            per-requester byte, requester i on [8i+7:8i]
//   req_ready           per-requester accept (only the granted one can be high)
//   uart_tx_byte/valid  byte stream to the uart transmitter
//   uart_tx_ready       uart transmitter ready
//   grant               registered one-hot grant, 0 when idle
//   busy                high whenever not idle
//   truncated           one-cycle pulse on a forced release
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned MAX_PKT      = 64,
    parameter int unsigned IDLE_TIMEOUT = 1024
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           uart_tx_byte,
    output logic                 uart_tx_valid,
    input  logic                 uart_tx_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 truncated
);

    localparam int unsigned IdxW  = $clog2(NUM_REQ);
    localparam int unsigned IdleW = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [IdxW:0]    NumReqW = (IdxW + 1)'(NUM_REQ);
    localparam logic [IdxW-1:0]  LastIdx = IdxW'(NUM_REQ - 1);
    localparam logic [7:0]       MaxPkt  = 8'(MAX_PKT);
    localparam logic [IdleW-1:0] IdleTo  = IdleW'(IDLE_TIMEOUT);

`ifdef UART_ARB_HEADER_EN
    typedef enum logic [1:0] {ArbIdle = 2'd0, ArbHdr = 2'd1, ArbStream = 2'd2} arb_state_e;
`else
    typedef enum logic [1:0] {ArbIdle = 2'd0, ArbStream = 2'd2} arb_state_e;
`endif

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [7:0]         byte_cnt_q, byte_cnt_d;
    logic [IdleW-1:0]   idle_cnt_q, idle_cnt_d;
    logic               truncated_q, truncated_d;

    logic [IdxW-1:0]    g_idx;
    logic [IdxW-1:0]    sel_idx;
    logic               sel_found;
    logic [7:0]         byte_inc;
    logic [IdleW-1:0]   idle_inc;
    logic               release_pkt;
    logic               force_rel;

    // Index of the current grant (grant_q is one-hot or zero).
    always_comb begin
        g_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) g_idx = IdxW'(i);
        end
    end

    // First valid requester at or after rr_ptr, wrapping at NUM_REQ-1.
    always_comb begin
        logic [IdxW:0] pos;
        pos       = '0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, rr_ptr_q} + (IdxW + 1)'(k);
            if (pos >= NumReqW) pos = pos - NumReqW;
            if (!sel_found && req_valid[pos[IdxW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = pos[IdxW-1:0];
            end
        end
    end

    assign byte_inc = byte_cnt_q + 8'd1;
    assign idle_inc = (idle_cnt_q == IdleTo) ? idle_cnt_q : idle_cnt_q + IdleW'(1);

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        byte_cnt_d    = byte_cnt_q;
        idle_cnt_d    = idle_cnt_q;
        truncated_d   = 1'b0;
        release_pkt   = 1'b0;
        force_rel     = 1'b0;
        uart_tx_valid = 1'b0;
        uart_tx_byte  = 8'h00;
        req_ready     = '0;

        case (state_q)
            ArbIdle: begin
                if (sel_found) begin
                    grant_d    = NUM_REQ'(1) << sel_idx;
                    byte_cnt_d = '0;
                    idle_cnt_d = '0;
`ifdef UART_ARB_HEADER_EN
                    state_d    = ArbHdr;
`else
                    state_d    = ArbStream;
`endif
                end
            end
`ifdef UART_ARB_HEADER_EN
            ArbHdr: begin
                uart_tx_valid = 1'b1;
                uart_tx_byte  = {4'hA, 4'(g_idx)};
                if (uart_tx_ready) state_d = ArbStream;
            end
`endif
            ArbStream: begin
                uart_tx_valid = req_valid[g_idx];
                uart_tx_byte  = req_valid[g_idx] ? req_data[{g_idx, 3'b000} +: 8] : 8'h00;
                req_ready     = grant_q & {NUM_REQ{uart_tx_ready}};
                if (req_valid[g_idx] && uart_tx_ready) begin
                    byte_cnt_d = byte_inc;
                    idle_cnt_d = '0;
                    // A last byte that also hits MAX_PKT is a normal release.
                    if (req_last[g_idx]) begin
                        release_pkt = 1'b1;
                    end else if (byte_inc == MaxPkt) begin
                        release_pkt = 1'b1;
                        force_rel   = 1'b1;
                    end
                end else if (!req_valid[g_idx]) begin
                    idle_cnt_d = idle_inc;
                    if (idle_inc == IdleTo) begin
                        release_pkt = 1'b1;
                        force_rel   = 1'b1;
                    end
                end
                if (release_pkt) begin
                    state_d     = ArbIdle;
                    grant_d     = '0;
                    rr_ptr_d    = (g_idx == LastIdx) ? '0 : g_idx + IdxW'(1);
                    truncated_d = force_rel;
                end
            end
            default: begin
                state_d = ArbIdle;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ArbIdle;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            byte_cnt_q  <= '0;
            idle_cnt_q  <= '0;
            truncated_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            byte_cnt_q  <= byte_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            truncated_q <= truncated_d;
        end
    end

    assign grant     = grant_q;
    assign busy      = (state_q != ArbIdle);
    assign truncated = truncated_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int NR = 4;

    typedef struct {
        int         req;
        int         len;
        logic [7:0] base;
        int         rmode;
        logic [3:0] exp_grant;
    } vec_t;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [NR-1:0]   req_valid, req_last, req_ready, grant;
    logic [8*NR-1:0] req_data;
    logic [7:0]      uart_tx_byte;
    logic            uart_tx_valid, uart_tx_ready, busy, truncated;

    always #5 clock = ~clock;

    uart_tx_arbiter #(
        .NUM_REQ      (NR),
        .MAX_PKT      (64),
        .IDLE_TIMEOUT (16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .uart_tx_byte  (uart_tx_byte),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .grant         (grant),
        .busy          (busy),
        .truncated     (truncated)
    );

    // Per-requester packet source: {last, data}
    logic [8:0] rq[NR][$];
    logic [7:0] exp_q[$];
    int         grant_log[$];
    logic [7:0] hdr_log[$];
    int checks = 0, errors = 0, viol = 0, trunc_cnt = 0, idle_low0 = 0, cyc = 0;
    int ready_mode = 0;  // 0: always ready, 1: ready 1 of 10 cycles, 2: never
    logic [NR-1:0] prev_grant = '0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int idx_of(input logic [NR-1:0] g);
        for (int i = 0; i < NR; i++) if (g[i]) return i;
        return -1;
    endfunction

    function automatic bit rq_empty();
        for (int i = 0; i < NR; i++) if (rq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Driver and monitor: sample at negedge, update inputs just after posedge.
    initial begin : driver
        logic [NR-1:0] hs;
        logic [7:0]    exp_b;
        req_valid     = '0;
        req_last      = '0;
        req_data      = '0;
        uart_tx_ready = 1'b0;
        forever begin
            @(negedge clock);
            hs = '0;
            cyc++;
            if (!reset) begin
                hs = req_valid & req_ready;
                if ((req_ready & ~grant) != '0) viol++;
                if (!uart_tx_valid && uart_tx_byte != 8'h00) viol++;
                if (!$onehot0(grant)) viol++;
                if (busy == (grant == '0)) viol++;
                if (uart_tx_valid && uart_tx_ready) begin
                    if (req_ready == '0) begin
`ifdef UART_ARB_HEADER_EN
                        hdr_log.push_back(uart_tx_byte);
`else
                        viol++;
`endif
                    end else if (exp_q.size() == 0) begin
                        check("unexpected_byte", int'(uart_tx_byte), 'h100);
                    end else begin
                        exp_b = exp_q.pop_front();
                        check("uart_byte", int'(uart_tx_byte), int'(exp_b));
                    end
                end
                if (grant != '0 && grant != prev_grant) grant_log.push_back(idx_of(grant));
                if (truncated) trunc_cnt++;
                if (grant[0] && !req_valid[0]) idle_low0++;
            end
            prev_grant = reset ? '0 : grant;
            @(posedge clock);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (hs[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                req_valid[i]      = (rq[i].size() > 0);
                req_last[i]       = req_valid[i] ? rq[i][0][8] : 1'b0;
                req_data[8*i +: 8] = req_valid[i] ? rq[i][0][7:0] : 8'h00;
            end
            uart_tx_ready = (ready_mode == 0) ? 1'b1 :
                            (ready_mode == 1) ? (cyc % 10 == 9) : 1'b0;
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        for (int i = 0; i < NR; i++) rq[i].delete();
        exp_q.delete();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        grant_log.delete();
        trunc_cnt = 0;
        idle_low0 = 0;
    endtask

    task automatic drain(input string name, input int budget);
        int n    = 0;
        bit done = 1'b0;
        while (!done && n < budget) begin
            @(negedge clock);
            n++;
            done = !busy && exp_q.size() == 0 && rq_empty() && !(|req_valid);
        end
        check(name, int'(done), 1);
    endtask

    task automatic wait_grant(input string name, input logic [NR-1:0] g, input int budget);
        int n    = 0;
        bit done = 1'b0;
        while (!done && n < budget) begin
            @(negedge clock);
            n++;
            done = (grant == g);
        end
        check(name, int'(done), 1);
    endtask

    task automatic check_log(input string name, input int e[$]);
        check({name, "_len"}, grant_log.size(), e.size());
        for (int i = 0; i < e.size(); i++)
            check(name, (i < grant_log.size()) ? grant_log[i] : -1, e[i]);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t vecs[5];
        int   e[$];
        int   n;
        logic [7:0] d;

        vecs[0] = '{req: 1, len: 3, base: 8'h11, rmode: 1, exp_grant: 4'b0010};
        vecs[1] = '{req: 0, len: 2, base: 8'h05, rmode: 0, exp_grant: 4'b0001};
        vecs[2] = '{req: 3, len: 4, base: 8'h21, rmode: 0, exp_grant: 4'b1000};
        vecs[3] = '{req: 2, len: 1, base: 8'h3C, rmode: 1, exp_grant: 4'b0100};
        vecs[4] = '{req: 1, len: 2, base: 8'h40, rmode: 0, exp_grant: 4'b0010};

        do_reset();
        @(negedge clock);
        check("rst_grant", int'(grant), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_tx_valid", int'(uart_tx_valid), 0);
        check("rst_tx_byte", int'(uart_tx_byte), 0);
        check("rst_req_ready", int'(req_ready), 0);
        check("rst_truncated", int'(truncated), 0);

        // Single-requester packets, one at a time
        for (int v = 0; v < 5; v++) begin
            tick();
            grant_log.delete();
            ready_mode = vecs[v].rmode;
            for (int k = 0; k < vecs[v].len; k++) begin
                d = 8'(int'(vecs[v].base) * (k + 1));
                rq[vecs[v].req].push_back({k == vecs[v].len - 1, d});
                exp_q.push_back(d);
            end
            drain("vec_drain", 400);
            check("vec_grant_count", grant_log.size(), 1);
            check("vec_grant", (grant_log.size() == 1) ? (1 << grant_log[0]) : 0,
                  int'(vecs[v].exp_grant));
        end
        ready_mode = 0;

        // Last release was requester 1, so requester 2 outranks requester 0
        tick();
        grant_log.delete();
        rq[0].push_back({1'b1, 8'hA0});
        rq[2].push_back({1'b1, 8'hA2});
        exp_q.push_back(8'hA2);
        exp_q.push_back(8'hA0);
        drain("rr_drain", 100);
        e = {2, 0};
        check_log("rr_after_vec", e);

        // All requesters continuously valid: grants rotate
        do_reset();
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < NR; i++) begin
                rq[i].push_back({1'b1, 8'(16 * i + p)});
                exp_q.push_back(8'(16 * i + p));
            end
        drain("rot_drain", 200);
        e = {0, 1, 2, 3, 0, 1, 2, 3};
        check_log("rot_grant", e);
        check("rot_trunc", trunc_cnt, 0);

        // MAX_PKT forced release; last byte of the 70 ends the remainder packet
        do_reset();
        for (int k = 0; k < 70; k++) rq[2].push_back({k == 69, 8'(k)});
        for (int k = 0; k < 64; k++) exp_q.push_back(8'(k));
        wait_grant("max_grant2", 4'b0100, 50);
        rq[3].push_back({1'b1, 8'hD3});
        rq[0].push_back({1'b1, 8'hD0});
        exp_q.push_back(8'hD3);
        exp_q.push_back(8'hD0);
        for (int k = 64; k < 70; k++) exp_q.push_back(8'(k));
        drain("max_drain", 600);
        e = {2, 3, 0, 2};
        check_log("max_grant", e);
        check("max_trunc", trunc_cnt, 1);

        // Idle timeout forced release
        do_reset();
        rq[0].push_back({1'b0, 8'h5A});
        exp_q.push_back(8'h5A);
        wait_grant("to_grant0", 4'b0001, 50);
        rq[3].push_back({1'b1, 8'hC3});
        exp_q.push_back(8'hC3);
        drain("to_drain", 200);
        check("to_idle_cycles", idle_low0, 16);
        check("to_trunc", trunc_cnt, 1);
        e = {0, 3};
        check_log("to_grant", e);

        // Reset mid-packet
        do_reset();
        rq[2].push_back({1'b1, 8'h77});
        exp_q.push_back(8'h77);
        drain("mr_pre_drain", 100);
        grant_log.delete();
        for (int k = 0; k < 5; k++) rq[1].push_back({k == 4, 8'(8'h60 + k)});
        exp_q.push_back(8'h60);
        exp_q.push_back(8'h61);
        n = 0;
        while (rq[1].size() != 3 && n < 100) begin
            tick();
            n++;
        end
        check("mr_two_bytes", rq[1].size(), 3);
        reset = 1'b1;
        rq[1].delete();
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("mr_grant", int'(grant), 0);
        check("mr_busy", int'(busy), 0);
        check("mr_tx_valid", int'(uart_tx_valid), 0);
        check("mr_exp_empty", exp_q.size(), 0);
        grant_log.delete();
        tick();
        rq[3].push_back({1'b1, 8'hC1});
        rq[0].push_back({1'b1, 8'hC0});
        exp_q.push_back(8'hC0);
        exp_q.push_back(8'hC1);
        drain("mr_drain", 100);
        e = {0, 3};
        check_log("mr_grant_after", e);

`ifdef UART_ARB_HEADER_EN
        do_reset();
        hdr_log.delete();
        rq[3].push_back({1'b1, 8'h55});
        exp_q.push_back(8'h55);
        drain("hdr_drain", 100);
        check("hdr_count", hdr_log.size(), 1);
        check("hdr_byte", (hdr_log.size() > 0) ? int'(hdr_log[0]) : -1, 'hA3);
`endif

        check("protocol_violations", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
